// File: rtl/issue_ctrl_pkg.sv
// Shared constants for the issue stage: instruction IDs, ID width, MUL/DIV FSM encodings.
// Also defines `INST_ID_LEN, `On and `Off for files that still use the macro forms.
`ifndef ISSUE_CTRL_DEFS_SV
`define ISSUE_CTRL_DEFS_SV
`define INST_ID_LEN 6
`define On  1'b1
`define Off 1'b0
`endif

package issue_ctrl_pkg;

  localparam int INST_ID_LEN = `INST_ID_LEN;

  localparam logic [0:0] MD_IDLE = 1'b0;
  localparam logic [0:0] MD_BUSY = 1'b1;

  // ID 0 and anything not listed decodes as an unknown instruction
  localparam logic [INST_ID_LEN-1:0] ID_ADD    = 6'd1;
  localparam logic [INST_ID_LEN-1:0] ID_SUB    = 6'd2;
  localparam logic [INST_ID_LEN-1:0] ID_SLL    = 6'd3;
  localparam logic [INST_ID_LEN-1:0] ID_SLT    = 6'd4;
  localparam logic [INST_ID_LEN-1:0] ID_SLTU   = 6'd5;
  localparam logic [INST_ID_LEN-1:0] ID_XOR    = 6'd6;
  localparam logic [INST_ID_LEN-1:0] ID_SRL    = 6'd7;
  localparam logic [INST_ID_LEN-1:0] ID_SRA    = 6'd8;
  localparam logic [INST_ID_LEN-1:0] ID_OR     = 6'd9;
  localparam logic [INST_ID_LEN-1:0] ID_AND    = 6'd10;
  localparam logic [INST_ID_LEN-1:0] ID_ADDI   = 6'd11;
  localparam logic [INST_ID_LEN-1:0] ID_SLTI   = 6'd12;
  localparam logic [INST_ID_LEN-1:0] ID_SLTIU  = 6'd13;
  localparam logic [INST_ID_LEN-1:0] ID_XORI   = 6'd14;
  localparam logic [INST_ID_LEN-1:0] ID_ORI    = 6'd15;
  localparam logic [INST_ID_LEN-1:0] ID_ANDI   = 6'd16;
  localparam logic [INST_ID_LEN-1:0] ID_SLLI   = 6'd17;
  localparam logic [INST_ID_LEN-1:0] ID_SRLI   = 6'd18;
  localparam logic [INST_ID_LEN-1:0] ID_SRAI   = 6'd19;
  localparam logic [INST_ID_LEN-1:0] ID_LB     = 6'd20;
  localparam logic [INST_ID_LEN-1:0] ID_LH     = 6'd21;
  localparam logic [INST_ID_LEN-1:0] ID_LW     = 6'd22;
  localparam logic [INST_ID_LEN-1:0] ID_LBU    = 6'd23;
  localparam logic [INST_ID_LEN-1:0] ID_LHU    = 6'd24;
  localparam logic [INST_ID_LEN-1:0] ID_SB     = 6'd25;
  localparam logic [INST_ID_LEN-1:0] ID_SH     = 6'd26;
  localparam logic [INST_ID_LEN-1:0] ID_SW     = 6'd27;
  localparam logic [INST_ID_LEN-1:0] ID_BEQ    = 6'd28;
  localparam logic [INST_ID_LEN-1:0] ID_BNE    = 6'd29;
  localparam logic [INST_ID_LEN-1:0] ID_BLT    = 6'd30;
  localparam logic [INST_ID_LEN-1:0] ID_BGE    = 6'd31;
  localparam logic [INST_ID_LEN-1:0] ID_BLTU   = 6'd32;
  localparam logic [INST_ID_LEN-1:0] ID_BGEU   = 6'd33;
  localparam logic [INST_ID_LEN-1:0] ID_LUI    = 6'd34;
  localparam logic [INST_ID_LEN-1:0] ID_AUIPC  = 6'd35;
  localparam logic [INST_ID_LEN-1:0] ID_JAL    = 6'd36;
  localparam logic [INST_ID_LEN-1:0] ID_JALR   = 6'd37;
  localparam logic [INST_ID_LEN-1:0] ID_MUL    = 6'd38;
  localparam logic [INST_ID_LEN-1:0] ID_MULH   = 6'd39;
  localparam logic [INST_ID_LEN-1:0] ID_MULHSU = 6'd40;
  localparam logic [INST_ID_LEN-1:0] ID_MULHU  = 6'd41;
  localparam logic [INST_ID_LEN-1:0] ID_DIV    = 6'd42;
  localparam logic [INST_ID_LEN-1:0] ID_DIVU   = 6'd43;
  localparam logic [INST_ID_LEN-1:0] ID_REM    = 6'd44;
  localparam logic [INST_ID_LEN-1:0] ID_REMU   = 6'd45;

  typedef struct packed {
    logic rs1_re;
    logic rs2_re;
    logic rd_we;
    logic mem_re;
    logic mem_we;
    logic muldiv;
  } dec_t;

endpackage

// File: rtl/issue_scoreboard.sv
// Pending-writer scoreboard: one bit per register, set on issue, cleared by writeback or flush.
// With ISSUE_WB_BYPASS_EN defined, same-cycle writebacks hide pending bits from the lookups.
module issue_scoreboard
  import issue_ctrl_pkg::*;
#(
  parameter int REG_NUM  = 32,
  parameter int REG_AW   = 5,
  parameter int WB_PORTS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       set_en,
  input  logic [REG_AW-1:0]          set_rd,
  input  logic [WB_PORTS-1:0]        wb_valid,
  input  logic [WB_PORTS*REG_AW-1:0] wb_rd,
  input  logic                       flush_clr_en,
  input  logic [REG_AW-1:0]          flush_clr_rd,
  input  logic [REG_AW-1:0]          rs1,
  input  logic [REG_AW-1:0]          rs2,
  input  logic [REG_AW-1:0]          rd,
  output logic                       rs1_pend,
  output logic                       rs2_pend,
  output logic                       rd_pend,
  output logic [REG_NUM-1:0]         pending
);

  logic [REG_NUM-1:0] sb;
  logic [REG_NUM-1:0] wb_mask;
  logic [REG_NUM-1:0] clr_mask;
  logic [REG_NUM-1:0] set_mask;
  logic [REG_NUM-1:0] sb_nxt;
  logic [REG_NUM-1:0] visible;

  always_comb begin
    wb_mask = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_valid[p] && (wb_rd[p*REG_AW +: REG_AW] != '0))
        wb_mask[wb_rd[p*REG_AW +: REG_AW]] = 1'b1;
    end
  end

  // set is applied after the clears: a newer writer outranks a retiring one
  always_comb begin
    clr_mask = wb_mask;
    if (flush_clr_en && (flush_clr_rd != '0))
      clr_mask[flush_clr_rd] = 1'b1;
    set_mask = '0;
    if (set_en && (set_rd != '0))
      set_mask[set_rd] = 1'b1;
    sb_nxt    = (sb & ~clr_mask) | set_mask;
    sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sb <= '0;
    else
      sb <= sb_nxt;
  end

`ifdef ISSUE_WB_BYPASS_EN
  assign visible = sb & ~wb_mask;
`else
  assign visible = sb;
`endif

  assign rs1_pend = visible[rs1];
  assign rs2_pend = visible[rs2];
  assign rd_pend  = visible[rd];
  assign pending  = sb;

endmodule

// File: rtl/issue_ctrl.sv
// ID->EX issue stage: decode, scoreboard hazard stall, MUL/DIV occupancy FSM, valid/ready issue register.
// Optional macro ISSUE_WB_BYPASS_EN lets same-cycle writebacks satisfy RAW/WAW checks.
//
// state   | meaning
// MD_IDLE | MUL/DIV unit free, a muldiv op may issue
// MD_BUSY | MUL/DIV unit occupied, md_cnt counts down remaining cycles
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int REG_NUM  = 32,
  parameter int REG_AW   = 5,
  parameter int WB_PORTS = 2,
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 33
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid_i,
  output logic                       id_ready_o,
  input  logic [INST_ID_LEN-1:0]     instr_id_i,
  input  logic [REG_AW-1:0]          rs1_i,
  input  logic [REG_AW-1:0]          rs2_i,
  input  logic [REG_AW-1:0]          rd_i,
  input  logic                       ex_ready_i,
  input  logic                       flush_i,
  input  logic [WB_PORTS-1:0]        wb_valid_i,
  input  logic [WB_PORTS*REG_AW-1:0] wb_rd_i,
  output logic                       ex_valid_o,
  output logic [INST_ID_LEN-1:0]     ex_instr_id_o,
  output logic                       ex_rs1_re_o,
  output logic                       ex_rs2_re_o,
  output logic                       ex_rd_we_o,
  output logic                       ex_mem_re_o,
  output logic                       ex_mem_we_o,
  output logic                       ex_muldiv_o,
  output logic [REG_AW-1:0]          ex_rd_o,
  output logic                       muldiv_busy_o,
  output logic [REG_NUM-1:0]         sb_pending_o
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 1);

  dec_t             dec;
  logic             is_div;
  logic             rs1_pend;
  logic             rs2_pend;
  logic             rd_pend;
  logic             raw;
  logic             waw;
  logic             md_stall;
  logic             stall;
  logic             can_load;
  logic             issue;
  logic             flush_clr_en;
  logic [0:0]       md_state;
  logic [CNT_W-1:0] md_cnt;
  logic [CNT_W-1:0] md_ld;

  always_comb begin
    dec    = '0;
    is_div = 1'b0;
    case (instr_id_i)
      ID_ADD, ID_SUB, ID_SLL, ID_SLT, ID_SLTU,
      ID_XOR, ID_SRL, ID_SRA, ID_OR, ID_AND: begin
        dec.rs1_re = 1'b1;
        dec.rs2_re = 1'b1;
        dec.rd_we  = 1'b1;
      end
      ID_ADDI, ID_SLTI, ID_SLTIU, ID_XORI, ID_ORI,
      ID_ANDI, ID_SLLI, ID_SRLI, ID_SRAI, ID_JALR: begin
        dec.rs1_re = 1'b1;
        dec.rd_we  = 1'b1;
      end
      ID_LB, ID_LH, ID_LW, ID_LBU, ID_LHU: begin
        dec.rs1_re = 1'b1;
        dec.rd_we  = 1'b1;
        dec.mem_re = 1'b1;
      end
      ID_SB, ID_SH, ID_SW: begin
        dec.rs1_re = 1'b1;
        dec.rs2_re = 1'b1;
        dec.mem_we = 1'b1;
      end
      ID_BEQ, ID_BNE, ID_BLT, ID_BGE, ID_BLTU, ID_BGEU: begin
        dec.rs1_re = 1'b1;
        dec.rs2_re = 1'b1;
      end
      ID_LUI, ID_AUIPC, ID_JAL: begin
        dec.rd_we = 1'b1;
      end
      ID_MUL, ID_MULH, ID_MULHSU, ID_MULHU: begin
        dec.rs1_re = 1'b1;
        dec.rs2_re = 1'b1;
        dec.rd_we  = 1'b1;
        dec.muldiv = 1'b1;
      end
      ID_DIV, ID_DIVU, ID_REM, ID_REMU: begin
        dec.rs1_re = 1'b1;
        dec.rs2_re = 1'b1;
        dec.rd_we  = 1'b1;
        dec.muldiv = 1'b1;
        is_div     = 1'b1;
      end
      default: ;
    endcase
  end

  issue_scoreboard #(
    .REG_NUM  (REG_NUM),
    .REG_AW   (REG_AW),
    .WB_PORTS (WB_PORTS)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .set_en       (issue & dec.rd_we),
    .set_rd       (rd_i),
    .wb_valid     (wb_valid_i),
    .wb_rd        (wb_rd_i),
    .flush_clr_en (flush_clr_en),
    .flush_clr_rd (ex_rd_o),
    .rs1          (rs1_i),
    .rs2          (rs2_i),
    .rd           (rd_i),
    .rs1_pend     (rs1_pend),
    .rs2_pend     (rs2_pend),
    .rd_pend      (rd_pend),
    .pending      (sb_pending_o)
  );

  assign raw      = (dec.rs1_re & rs1_pend) | (dec.rs2_re & rs2_pend);
  assign waw      = dec.rd_we & (rd_i != '0) & rd_pend;
  assign md_stall = dec.muldiv & (md_state == MD_BUSY);
  assign stall    = raw | waw | md_stall;

  assign can_load   = ~ex_valid_o | ex_ready_i;
  assign id_ready_o = can_load & ~stall & ~flush_i;
  assign issue      = id_valid_i & id_ready_o;

  // a flushed producer will never write back, so release its register
  assign flush_clr_en = flush_i & ex_valid_o & ex_rd_we_o & (ex_rd_o != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_o    <= 1'b0;
      ex_instr_id_o <= '0;
      ex_rs1_re_o   <= 1'b0;
      ex_rs2_re_o   <= 1'b0;
      ex_rd_we_o    <= 1'b0;
      ex_mem_re_o   <= 1'b0;
      ex_mem_we_o   <= 1'b0;
      ex_muldiv_o   <= 1'b0;
      ex_rd_o       <= '0;
    end else if (flush_i) begin
      ex_valid_o <= 1'b0;
    end else if (issue) begin
      ex_valid_o    <= 1'b1;
      ex_instr_id_o <= instr_id_i;
      ex_rs1_re_o   <= dec.rs1_re;
      ex_rs2_re_o   <= dec.rs2_re;
      ex_rd_we_o    <= dec.rd_we;
      ex_mem_re_o   <= dec.mem_re;
      ex_mem_we_o   <= dec.mem_we;
      ex_muldiv_o   <= dec.muldiv;
      ex_rd_o       <= rd_i;
    end else if (ex_ready_i) begin
      ex_valid_o <= 1'b0;
    end
  end

  assign md_ld = is_div ? DIV_LD : MUL_LD;

  // the issue cycle counts as the first occupied cycle, so BUSY lasts LAT-1 cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_state <= MD_IDLE;
      md_cnt   <= '0;
    end else begin
      case (md_state)
        MD_IDLE: begin
          if (issue && dec.muldiv) begin
            md_cnt   <= md_ld;
            md_state <= (md_ld != '0) ? MD_BUSY : MD_IDLE;
          end
        end
        default: begin
          md_cnt <= md_cnt - CNT_W'(1);
          if (md_cnt == CNT_W'(1))
            md_state <= MD_IDLE;
        end
      endcase
    end
  end

  assign muldiv_busy_o = (md_state == MD_BUSY);

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: hazards, hold, MUL/DIV occupancy, flush, scoreboard corners, async reset.
module tb_issue_ctrl;
  import issue_ctrl_pkg::*;

  localparam int REG_NUM  = 32;
  localparam int REG_AW   = 5;
  localparam int WB_PORTS = 2;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       id_valid = 1'b0;
  logic                       id_ready;
  logic [INST_ID_LEN-1:0]     instr_id = '0;
  logic [REG_AW-1:0]          rs1 = '0;
  logic [REG_AW-1:0]          rs2 = '0;
  logic [REG_AW-1:0]          rd = '0;
  logic                       ex_ready = 1'b1;
  logic                       flush = 1'b0;
  logic [WB_PORTS-1:0]        wb_valid = '0;
  logic [WB_PORTS*REG_AW-1:0] wb_rd = '0;
  logic                       ex_valid;
  logic [INST_ID_LEN-1:0]     ex_instr_id;
  logic                       ex_rs1_re, ex_rs2_re, ex_rd_we, ex_mem_re, ex_mem_we, ex_muldiv;
  logic [REG_AW-1:0]          ex_rd;
  logic                       md_busy;
  logic [REG_NUM-1:0]         sb;

  int n_tests = 0;
  int n_fail  = 0;
  int busy_cnt;
  int waited;

  issue_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid_i    (id_valid),
    .id_ready_o    (id_ready),
    .instr_id_i    (instr_id),
    .rs1_i         (rs1),
    .rs2_i         (rs2),
    .rd_i          (rd),
    .ex_ready_i    (ex_ready),
    .flush_i       (flush),
    .wb_valid_i    (wb_valid),
    .wb_rd_i       (wb_rd),
    .ex_valid_o    (ex_valid),
    .ex_instr_id_o (ex_instr_id),
    .ex_rs1_re_o   (ex_rs1_re),
    .ex_rs2_re_o   (ex_rs2_re),
    .ex_rd_we_o    (ex_rd_we),
    .ex_mem_re_o   (ex_mem_re),
    .ex_mem_we_o   (ex_mem_we),
    .ex_muldiv_o   (ex_muldiv),
    .ex_rd_o       (ex_rd),
    .muldiv_busy_o (md_busy),
    .sb_pending_o  (sb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic v, input logic [INST_ID_LEN-1:0] id,
                         input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b,
                         input logic [REG_AW-1:0] d);
    id_valid = v;
    instr_id = id;
    rs1      = a;
    rs2      = b;
    rd       = d;
    #1;
  endtask

  task automatic wb(input logic [1:0] v, input logic [REG_AW-1:0] r0, input logic [REG_AW-1:0] r1);
    wb_valid = v;
    wb_rd    = {r1, r0};
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    tick;
    check("rst_ex_valid", ex_valid, 0);
    check("rst_sb", sb, 0);
    check("rst_busy", md_busy, 0);
    check("rst_ex_instr", ex_instr_id, 0);
    rst = 1'b0;
    #1;

    // RAW on x5 resolved by writeback on port 1
    present(1, ID_ADD, 1, 2, 5);
    check("add_x5_ready", id_ready, 1);
    tick;
    check("add_x5_valid", ex_valid, 1);
    check("add_x5_rd", ex_rd, 5);
    check("add_x5_rdwe", ex_rd_we, 1);
    check("sb_x5_set", sb, 32'h0000_0020);
    present(1, ID_ADD, 5, 1, 6);
    check("raw_stall", id_ready, 0);
    tick;
    check("raw_stall_hold", id_ready, 0);
    check("ex_drained", ex_valid, 0);
    wb(2'b10, 0, 5);
`ifdef ISSUE_WB_BYPASS_EN
    check("raw_bypass_ready", id_ready, 1);
    tick;
    wb(2'b00, 0, 0);
`else
    check("raw_wb_cycle_stall", id_ready, 0);
    tick;
    wb(2'b00, 0, 0);
    check("raw_after_wb_ready", id_ready, 1);
    check("sb_x5_cleared", sb, 0);
    tick;
`endif
    present(0, ID_ADD, 0, 0, 0);
    check("add_x6_valid", ex_valid, 1);
    check("add_x6_rd", ex_rd, 6);
    check("sb_x6_only", sb, 32'h0000_0040);
    wb(2'b01, 6, 0);
    tick;
    wb(2'b00, 0, 0);
    check("sb_x6_cleared", sb, 0);

    // LW held by EX back-pressure
    ex_ready = 1'b0;
    present(1, ID_LW, 1, 0, 7);
    check("lw_ready", id_ready, 1);
    tick;
    present(1, ID_ADD, 1, 2, 8);
    check("hold_no_accept", id_ready, 0);
    check("lw_rs1_re", ex_rs1_re, 1);
    check("lw_rs2_re", ex_rs2_re, 0);
    for (int i = 0; i < 3; i++) begin
      check("lw_hold_valid", ex_valid, 1);
      check("lw_hold_rd", ex_rd, 7);
      check("lw_hold_mem_re", ex_mem_re, 1);
      check("lw_hold_id", ex_instr_id, ID_LW);
      tick;
    end
    present(0, ID_ADD, 0, 0, 0);
    check("lw_sb7", sb[7], 1);
    check("lw_no_x8", sb[8], 0);
    ex_ready = 1'b1;
    tick;
    check("lw_drained", ex_valid, 0);
    wb(2'b01, 7, 0);
    tick;
    wb(2'b00, 0, 0);

    // DIV occupancy, independent ADD in the shadow, MUL waits
    present(1, ID_DIV, 1, 2, 10);
    check("div_ready", id_ready, 1);
    tick;
    check("div_muldiv_flag", ex_muldiv, 1);
    present(1, ID_ADD, 1, 2, 12);
    check("div_busy_start", md_busy, 1);
    check("add_during_div", id_ready, 1);
    busy_cnt = 1;
    tick;
    check("add_during_div_rd", ex_rd, 12);
    present(1, ID_MUL, 1, 2, 11);
    waited = 0;
    while (!id_ready && waited < 60) begin
      if (md_busy) busy_cnt++;
      tick;
      waited++;
    end
    check("div_busy_end", md_busy, 0);
    check("div_busy_cycles", busy_cnt, 32);
    check("mul_wait_cycles", waited, 31);
    check("mul_ready", id_ready, 1);
    tick;
    present(0, ID_ADD, 0, 0, 0);
    check("mul_issued", ex_instr_id, ID_MUL);
    check("mul_busy", md_busy, 1);
    tick;
    check("mul_busy2", md_busy, 1);
    tick;
    check("mul_done", md_busy, 0);
    wb(2'b11, 10, 11);
    tick;
    wb(2'b01, 12, 0);
    tick;
    wb(2'b00, 0, 0);
    check("sb_clear_muldiv", sb, 0);

    // flush of ADDI x9 in the issue register
    ex_ready = 1'b0;
    present(1, ID_ADDI, 1, 0, 9);
    tick;
    check("addi9_valid", ex_valid, 1);
    check("addi9_sb", sb, 32'h0000_0200);
    present(1, ID_ADD, 1, 2, 13);
    flush = 1'b1;
    #1;
    check("flush_no_accept", id_ready, 0);
    tick;
    flush = 1'b0;
    present(0, ID_ADD, 0, 0, 0);
    check("flush_ex_valid", ex_valid, 0);
    check("flush_sb", sb, 0);
    ex_ready = 1'b1;

    // same-cycle set and writeback of x3, WAW, LUI ignores sources
    present(1, ID_ADDI, 1, 0, 3);
    wb(2'b01, 3, 0);
    check("addi3_ready", id_ready, 1);
    tick;
    wb(2'b00, 0, 0);
    present(0, ID_ADD, 0, 0, 0);
    check("set_wins", sb, 32'h0000_0008);
    present(1, ID_ADDI, 1, 0, 3);
    check("waw_stall", id_ready, 0);
    present(1, ID_LUI, 3, 3, 4);
    check("lui_no_src", id_ready, 1);
    tick;
    present(0, ID_ADD, 0, 0, 0);
    check("lui_sb", sb, 32'h0000_0018);
    wb(2'b11, 3, 4);
    tick;
    wb(2'b00, 0, 0);
    check("sb_x3_x4_clear", sb, 0);
    present(1, ID_ADDI, 1, 0, 0);
    tick;
    present(0, ID_ADD, 0, 0, 0);
    check("x0_rdwe", ex_rd_we, 1);
    check("x0_not_set", sb, 0);
    present(1, ID_ADDI, 1, 0, 2);
    wb(2'b01, 0, 0);
    tick;
    wb(2'b00, 0, 0);
    present(0, ID_ADD, 0, 0, 0);
    check("wb_x0_ignored", sb, 32'h0000_0004);
    wb(2'b10, 0, 2);
    tick;
    wb(2'b00, 0, 0);

    // unknown ID issues as a bubble
    present(1, 6'd63, 1, 2, 4);
    check("unk_ready", id_ready, 1);
    tick;
    present(0, ID_ADD, 0, 0, 0);
    check("unk_valid", ex_valid, 1);
    check("unk_rdwe", ex_rd_we, 0);
    check("unk_sb", sb, 0);

    // async reset mid-DIV
    present(1, ID_DIV, 1, 2, 14);
    tick;
    present(1, ID_ADD, 1, 2, 15);
    tick;
    present(0, ID_ADD, 0, 0, 0);
    check("pre_rst_sb", sb, 32'h0000_C000);
    check("pre_rst_busy", md_busy, 1);
    #1;
    rst = 1'b1;
    #1;
    check("arst_ex_valid", ex_valid, 0);
    check("arst_busy", md_busy, 0);
    check("arst_sb", sb, 0);
    check("arst_ex_instr", ex_instr_id, 0);
    check("arst_ex_rd", ex_rd, 0);
    rst = 1'b0;
    #1;
    present(1, ID_MUL, 14, 15, 16);
    check("post_rst_ready", id_ready, 1);
    tick;
    present(0, ID_ADD, 0, 0, 0);
    check("post_rst_valid", ex_valid, 1);
    check("post_rst_busy", md_busy, 1);
    tick;
    tick;
    tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- Next-generation decode control: decodes instr_id into register/memory enables, and adds a register scoreboard, a MUL/DIV occupancy FSM and a registered valid/ready issue stage.
- Sits between ID and EX. Stalls on RAW/WAW hazards and a busy MUL/DIV unit, then issues one instruction per cycle into the ID/EX control register.

Parameters:
- REG_NUM, 32, architectural registers tracked; x0 is never tracked.
- REG_AW, 5, register address width.
- WB_PORTS, 2, number of independent writeback completion ports.
- MUL_LAT, 3, cycles MUL/MULH/MULHSU/MULHU occupy the multiplier; must be >= 1.
- DIV_LAT, 33, cycles DIV/DIVU/REM/REMU occupy the divider; must be >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- id_valid_i  in  1  ID holds a decoded instruction
- id_ready_o  out  1  instruction accepted this cycle
- instr_id_i  in  `INST_ID_LEN  instruction ID from instr_identifier
- rs1_i, rs2_i, rd_i  in  REG_AW each  register addresses
- ex_ready_i  in  1  EX accepts the issue register contents
- flush_i  in  1  kill ID and issue-register contents (branch redirect)
- wb_valid_i  in  WB_PORTS  completion strobe per port
- wb_rd_i  in  WB_PORTS*REG_AW  completing rd per port (packed, port 0 in LSBs)
- ex_valid_o  out  1  issue register valid
- ex_instr_id_o  out  `INST_ID_LEN  issued ID
- ex_rs1_re_o, ex_rs2_re_o, ex_rd_we_o, ex_mem_re_o, ex_mem_we_o, ex_muldiv_o  out  1 each  issued control flags
- ex_rd_o  out  REG_AW  issued rd
- muldiv_busy_o  out  1  MUL/DIV FSM in BUSY
- sb_pending_o  out  REG_NUM  scoreboard bit vector (debug)

Behaviour:
- Reset (async, rst=1): every ex_* output 0, ex_valid_o 0, scoreboard all 0, FSM IDLE, counter 0, muldiv_busy_o 0.
- Decode, combinational:
  - I-type ALU, loads and JALR: rs1 only.
  - R-type and M-extension, stores and branches: rs1 and rs2.
  - LUI, AUIPC and JAL: no source reads.
  - rd_we set for ALU, M-extension, LUI/AUIPC, loads, JAL/JALR.
  - mem_re set for loads; mem_we set for stores; muldiv set for the 8 M ops.
  - Unknown IDs decode to all flags 0. They still issue, as a bubble with no scoreboard effect.
- Hazard (combinational):
  - raw = (rs1_re & sb[rs1]) | (rs2_re & sb[rs2]).
  - waw = rd_we & rd != 0 & sb[rd].
  - md = muldiv & FSM in BUSY.
  - stall = raw | waw | md.
- Handshake:
  - can_load = ~ex_valid_o | ex_ready_i.
  - id_ready_o = can_load & ~stall & ~flush_i.
  - Issue = id_valid_i & id_ready_o. On issue, the issue register loads the decoded fields and ex_valid_o=1 next cycle (1-cycle latency).
  - If ex_ready_i & ex_valid_o and no issue, ex_valid_o drops to 0.
  - Issue-register contents hold stable while ex_valid_o & ~ex_ready_i.
- Scoreboard:
  - Issue with rd_we & rd != 0 sets sb[rd].
  - Any wb port with wb_valid_i[p] & wb_rd_i[p] != 0 clears sb[wb_rd].
  - Same-cycle set and clear of the same register: set wins, because the newer writer is still pending.
  - Duplicate clears across ports are harmless. Bit 0 is hard-wired 0.
- Flush:
  - ex_valid_o cleared next cycle and no issue that cycle.
  - If the issue register holds valid & rd_we & rd != 0, its sb bit is cleared. A same-cycle wb clear of that bit is consistent with this.
  - The MUL/DIV FSM is not aborted.
- MUL/DIV FSM:
  - IDLE: on issue of a muldiv op, load cnt = MUL_LAT-1 or DIV_LAT-1. If the loaded value is 0, stay IDLE; otherwise go to BUSY.
  - BUSY: cnt decrements each cycle; at cnt==0 return to IDLE. A new muldiv op may issue in the cycle after the return to IDLE.
- Mid-operation reset returns everything to the reset state immediately, with no pending completions.

Optional Feature:
- Macro ISSUE_WB_BYPASS_EN.
- Defined: a source or rd that matches a same-cycle valid wb port is treated as not pending for the raw/waw terms. This saves one stall cycle per dependent op.
- Undefined: the hazard check uses only the registered scoreboard. A dependent op issues the cycle after the writeback.

Decomposition:
- Shared defines header: instruction ID macros, `INST_ID_LEN, `On/`Off, FSM state encodings MD_IDLE/MD_BUSY.
- One sub-module, issue_scoreboard: REG_NUM bits with WB_PORTS clear ports, a set port, a flush-clear port and hazard lookup outputs.
- Decode logic and FSM stay in issue_ctrl.

Test Plan:
- ADD x5 issued, then ADD x6,x5,x1 → second held (id_ready_o=0) until wb port1 clears x5. Issues the cycle after the clear (bypass off) or the same cycle (ISSUE_WB_BYPASS_EN).
- LW x7 with ex_ready_i=0 for 3 cycles → ex_* fields stable, ex_valid_o=1 throughout; sb_pending_o[7]=1.
- DIV issued, DIV_LAT=33 → muldiv_busy_o high 32 cycles. A MUL behind it stalls the whole time and issues at cycle 34; a non-dependent ADD issues meanwhile.
- ADDI x9 in the issue register + flush_i → ex_valid_o=0 next cycle, sb[9]=0, no ID acceptance that cycle.
- Same cycle: issue ADDI x3 and wb_rd=3 → sb[3] stays 1. Writes to x0 never set sb; wb to x0 is ignored.
- rst asserted mid-DIV with sb bits set → all outputs and sb_pending_o are 0 asynchronously; after release, the next op issues with no stall.
